// File: rtl/foh_interp.sv
// -----------------------------------------------------------------------------
// foh_interp -- first-order-hold (linear) interpolator
//
// Accepts signed samples strobed by tick at roughly one per 2^LOG2_RATIO clks
// and emits a linearly ramped sample on every clk. Each new sample starts a
// ramp segment from the previous target to the new one. The segment lasts
// N = 2^LOG2_RATIO clks. A 1-deep pending buffer absorbs tick jitter.
// underrun flags a ramp that ended with no new sample available.
// overrun flags a pending sample that was overwritten before use.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous, active-high; clears all state
//   tick       in   one-clk strobe, DDS_in valid this cycle
//   DDS_in     in   DW-bit signed input sample
//   DDS_out    out  DW-bit signed interpolated sample (acc >>> LOG2_RATIO)
//   out_valid  out  high once the first sample has been accepted
//   phase      out  position within the current ramp segment
//   underrun   out  one-clk pulse: ramp ended with no new sample
//   overrun    out  one-clk pulse: pending sample overwritten
// -----------------------------------------------------------------------------
module foh_interp #(
    parameter int DW         = 16,
    parameter int LOG2_RATIO = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic signed [DW-1:0]  DDS_in,
    output logic signed [DW-1:0]  DDS_out,
    output logic                  out_valid,
    output logic [LOG2_RATIO-1:0] phase,
    output logic                  underrun,
    output logic                  overrun
);

    localparam int L  = LOG2_RATIO;
    localparam int AW = DW + L + 1;
    localparam logic [L-1:0] PHASE_END = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN
    } state_t;

    state_t                state;
    logic signed [DW-1:0]  prev;
    logic signed [DW-1:0]  curr;
    logic signed [DW-1:0]  pend;
    logic                  pend_v;
    logic signed [AW-1:0]  acc;
    logic signed [DW:0]    delta;
    logic signed [AW-1:0]  delta_ext;

    // One extra bit keeps the full-scale difference (+/-65535 for DW=16)
    // from wrapping.
    assign delta     = {curr[DW-1], curr} - {prev[DW-1], prev};
    assign delta_ext = {{L{delta[DW]}}, delta};

    // Dropping the low L bits of a two's complement value is a floor divide
    // by N. acc is registered, so the output adds no latency.
    assign DDS_out = acc[DW+L-1:L];

    // A sample scaled into accumulator units (sample << L, sign-extended).
    function automatic logic signed [AW-1:0] to_acc(input logic signed [DW-1:0] s);
        return {s[DW-1], s, {L{1'b0}}};
    endfunction

    // NOTE: all state lives in this one clocked block with non-blocking
    // assignments, so every right-hand side sees pre-edge values. That is why
    // "prev <= curr; curr <= new" moves the pair as a unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            curr      <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            acc       <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            overrun  <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick) begin
                        curr      <= DDS_in;
                        acc       <= to_acc(DDS_in);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    if (tick) begin
                        prev  <= curr;
                        curr  <= DDS_in;
                        acc   <= to_acc(curr);
                        phase <= '0;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (phase == PHASE_END) begin
                        // N adds of delta land exactly on curr << L. The
                        // target is loaded directly, which is the same value
                        // whether the ramp continues or stops here.
                        acc   <= to_acc(curr);
                        phase <= '0;
                        if (pend_v) begin
                            prev <= curr;
                            curr <= pend;
                            if (tick) begin
                                pend <= DDS_in;
                            end else begin
                                pend_v <= 1'b0;
                            end
                        end else if (tick) begin
                            prev <= curr;
                            curr <= DDS_in;
                        end else begin
                            state    <= HOLD;
                            underrun <= 1'b1;
                        end
                    end else begin
                        acc   <= acc + delta_ext;
                        phase <= phase + L'(1);
                        if (tick) begin
                            // The newest sample wins. Losing a buffered one
                            // is reported as overrun.
                            pend    <= DDS_in;
                            pend_v  <= 1'b1;
                            overrun <= pend_v;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_foh_interp.sv
// -----------------------------------------------------------------------------
// tb_foh_interp -- self-checking bench for foh_interp (DW=16, LOG2_RATIO=5)
//
// The reference model tracks the accepted samples as a segment (from, to,
// position k) plus a pending queue. It predicts the output directly as
// floor((from*N + k*(to-from)) / N).
// -----------------------------------------------------------------------------
module tb_foh_interp;

    localparam int DW = 16;
    localparam int L  = 5;
    localparam int N  = 1 << L;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 tick;
    logic signed [DW-1:0] DDS_in;
    logic signed [DW-1:0] DDS_out;
    logic                 out_valid;
    logic [L-1:0]         phase;
    logic                 underrun;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    foh_interp #(.DW(DW), .LOG2_RATIO(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .DDS_in    (DDS_in),
        .DDS_out   (DDS_out),
        .out_valid (out_valid),
        .phase     (phase),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_started;
    bit m_running;
    int m_k;
    int m_from;
    int m_to;
    int m_q[$];
    bit m_under;
    bit m_over;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int m_value();
        if (!m_started) return 0;
        if (m_running) return floor_div(m_from * N + m_k * (m_to - m_from), N);
        return m_to;
    endfunction

    function automatic int m_phase();
        return m_running ? m_k : 0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_running = 0; m_k = 0; m_from = 0; m_to = 0;
        m_q.delete(); m_under = 0; m_over = 0;
    endtask

    task automatic model_update(input bit t, input int d);
        m_under = 0;
        m_over  = 0;
        if (!m_started) begin
            if (t) begin m_started = 1; m_to = d; end
        end else if (!m_running) begin
            if (t) begin m_from = m_to; m_to = d; m_k = 0; m_running = 1; end
        end else if (m_k == N - 1) begin
            if (m_q.size() > 0) begin
                m_from = m_to; m_to = m_q.pop_front(); m_k = 0;
                if (t) m_q.push_back(d);
            end else if (t) begin
                m_from = m_to; m_to = d; m_k = 0;
            end else begin
                m_running = 0; m_under = 1;
            end
        end else begin
            m_k++;
            if (t) begin
                if (m_q.size() > 0) m_over = 1;
                m_q.delete();
                m_q.push_back(d);
            end
        end
    endtask

    // One clk: drive inputs, take the edge, update model, settle 1 time unit.
    task automatic step(input bit t, input int d);
        tick   = t;
        DDS_in = d[DW-1:0];
        @(posedge clk);
        model_update(t, d);
        #1;
        tick   = 1'b0;
        DDS_in = '0;
    endtask

    task automatic finish_ramp();
        for (int n = 0; n < 64 && m_running; n++) step(0, 0);
    endtask

    task automatic advance_to_phase(input int p);
        for (int n = 0; n < 64 && !(m_running && m_k == p); n++) step(0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; DDS_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (DDS_out !== 16'sd0) begin errors++; $display("FAIL reset_out got %0d exp 0", DDS_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (phase !== 5'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
        checks++; if (underrun !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags got u=%b o=%b exp 0 0", underrun, overrun); end
        step(0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_ramp_up();
        step(1, 100);
        checks++; if (DDS_out !== 16'sd100 || out_valid !== 1'b1) begin
            errors++; $display("FAIL first_sample got %0d/%b exp 100/1", DDS_out, out_valid); end
        step(1, 132);
        for (int k = 0; k < N; k++) begin
            if (k > 0) step(0, 0);
            checks++; if (int'(DDS_out) !== 100 + k || int'(phase) !== k) begin
                errors++; $display("FAIL ramp_up k=%0d got %0d ph %0d exp %0d ph %0d", k, DDS_out, phase, 100 + k, k); end
        end
        step(0, 0);
        checks++; if (DDS_out !== 16'sd132 || underrun !== 1'b1) begin
            errors++; $display("FAIL ramp_up_end got %0d u=%b exp 132 u=1", DDS_out, underrun); end
    endtask

    task automatic test_ramp_down();
        step(1, 0);
        finish_ramp();
        step(1, -64);
        for (int k = 0; k < N; k++) begin
            if (k > 0) step(0, 0);
            checks++; if (int'(DDS_out) !== -2 * k) begin
                errors++; $display("FAIL ramp_down k=%0d got %0d exp %0d", k, DDS_out, -2 * k); end
        end
        step(0, 0);
        checks++; if (int'(DDS_out) !== -64) begin errors++; $display("FAIL ramp_down_end got %0d exp -64", DDS_out); end
        // Small deltas: output is floor-truncated and never overshoots.
        step(1, 0);
        finish_ramp();
        step(1, -1);
        for (int k = 0; k < N; k++) begin
            if (k > 0) step(0, 0);
            checks++; if (int'(DDS_out) !== (k == 0 ? 0 : -1)) begin
                errors++; $display("FAIL ramp_neg1 k=%0d got %0d exp %0d", k, DDS_out, (k == 0 ? 0 : -1)); end
        end
        step(0, 0);
        step(1, 0);
        finish_ramp();
        step(1, 1);
        for (int k = 0; k < N; k++) begin
            if (k > 0) step(0, 0);
            checks++; if (int'(DDS_out) !== 0) begin
                errors++; $display("FAIL ramp_pos1 k=%0d got %0d exp 0", k, DDS_out); end
        end
        step(0, 0);
        checks++; if (int'(DDS_out) !== 1) begin errors++; $display("FAIL ramp_pos1_end got %0d exp 1", DDS_out); end
    endtask

    task automatic test_underrun();
        step(1, 33);
        advance_to_phase(N - 1);
        step(0, 0);
        checks++; if (underrun !== 1'b1 || int'(DDS_out) !== 33) begin
            errors++; $display("FAIL underrun_pulse got u=%b out %0d exp u=1 out 33", underrun, DDS_out); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            checks++; if (underrun !== 1'b0 || int'(DDS_out) !== 33 || phase !== 5'd0) begin
                errors++; $display("FAIL underrun_hold got u=%b out %0d ph %0d exp u=0 out 33 ph 0", underrun, DDS_out, phase); end
        end
        step(1, 65);
        checks++; if (int'(DDS_out) !== 33) begin errors++; $display("FAIL restart_k0 got %0d exp 33", DDS_out); end
        step(0, 0);
        checks++; if (int'(DDS_out) !== 34) begin errors++; $display("FAIL restart_k1 got %0d exp 34", DDS_out); end
        finish_ramp();
    endtask

    task automatic test_overrun();
        step(1, 100);
        repeat (5) step(0, 0);
        step(1, 500);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first got %b exp 0", overrun); end
        repeat (3) step(0, 0);
        step(1, 700);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_second got %b exp 1", overrun); end
        step(0, 0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_single got %b exp 0", overrun); end
        advance_to_phase(N - 1);
        step(0, 0);
        checks++; if (int'(DDS_out) !== 100 || phase !== 5'd0 || underrun !== 1'b0) begin
            errors++; $display("FAIL pend_start got %0d ph %0d u=%b exp 100 ph 0 u=0", DDS_out, phase, underrun); end
        step(0, 0);
        // 100 + 600/32 = 118.75, floored
        checks++; if (int'(DDS_out) !== 118) begin errors++; $display("FAIL pend_target got %0d exp 118", DDS_out); end
        step(1, 800);
        advance_to_phase(N - 1);
        step(1, 900);
        checks++; if (overrun !== 1'b0 || int'(DDS_out) !== 700 || phase !== 5'd0) begin
            errors++; $display("FAIL end_tick got o=%b out %0d ph %0d exp o=0 out 700 ph 0", overrun, DDS_out, phase); end
        advance_to_phase(N - 1);
        step(0, 0);
        checks++; if (int'(DDS_out) !== 800 || underrun !== 1'b0) begin
            errors++; $display("FAIL end_tick_kept got %0d u=%b exp 800 u=0", DDS_out, underrun); end
        finish_ramp();
        checks++; if (int'(DDS_out) !== 900 || underrun !== 1'b1) begin
            errors++; $display("FAIL end_tick_last got %0d u=%b exp 900 u=1", DDS_out, underrun); end
    endtask

    task automatic test_reset_midramp();
        step(1, -200);
        advance_to_phase(17);
        #2 reset = 1'b1;
        #1;
        checks++; if (DDS_out !== 16'sd0 || out_valid !== 1'b0 || phase !== 5'd0) begin
            errors++; $display("FAIL async_reset got %0d/%b/%0d exp 0/0/0", DDS_out, out_valid, phase); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(1, 55);
        checks++; if (int'(DDS_out) !== 55 || out_valid !== 1'b1 || phase !== 5'd0) begin
            errors++; $display("FAIL post_reset got %0d/%b/%0d exp 55/1/0", DDS_out, out_valid, phase); end
        step(0, 0);
        checks++; if (int'(DDS_out) !== 55 || underrun !== 1'b0) begin
            errors++; $display("FAIL post_reset_hold got %0d u=%b exp 55 u=0", DDS_out, underrun); end
    endtask

    task automatic test_fullscale();
        int last;
        step(1, 32767);
        finish_ramp();
        step(1, -32768);
        last = 32767;
        for (int k = 0; k < N; k++) begin
            if (k > 0) step(0, 0);
            checks++; if (int'(DDS_out) > last || int'(DDS_out) !== m_value()) begin
                errors++; $display("FAIL fullscale k=%0d got %0d prev %0d exp %0d", k, DDS_out, last, m_value()); end
            last = int'(DDS_out);
        end
        step(0, 0);
        checks++; if (int'(DDS_out) !== -32768) begin errors++; $display("FAIL fullscale_end got %0d exp -32768", DDS_out); end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] r;
        int pct;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            // Sweep tick density so both underruns and overruns occur.
            pct = (i / 500) % 3 == 0 ? 2 : ((i / 500) % 3 == 1 ? 3 : 9);
            r = DW'($urandom);
            step($urandom_range(0, 99) < pct, int'(r));
            checks++;
            if (int'(DDS_out) !== m_value() || int'(phase) !== m_phase() || out_valid !== m_started ||
                underrun !== m_under || overrun !== m_over) begin
                errors++;
                $display("FAIL random i=%0d got out %0d ph %0d v %b u %b o %b exp out %0d ph %0d v %b u %b o %b",
                         i, DDS_out, phase, out_valid, underrun, overrun,
                         m_value(), m_phase(), m_started, m_under, m_over);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        DDS_in = '0;
        model_reset();
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_underrun();
        test_overrun();
        test_reset_midramp();
        test_fullscale();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
